down_cnt_reload: RTL and testbench

//   Programmable down-counter timer with a runtime reload value. It is the

---
 rtl/down_cnt_reload_pkg.sv | 15 +
 rtl/down_cnt_reload_if.sv | 29 ++
 rtl/down_cnt_reload.sv | 109 ++++++++++
 tb/tb_down_cnt_reload.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/down_cnt_reload_pkg.sv
// down_cnt_reload shared definitions.
// State encodings and small helpers.
package down_cnt_reload_pkg;

  typedef logic [1:0] st_t;

  localparam st_t ST_IDLE = 2'd0;
  localparam st_t ST_RUN  = 2'd1;
  localparam st_t ST_DONE = 2'd2;

  function automatic logic is_run(input st_t s);
    return s == ST_RUN;
  endfunction

endpackage

// File: rtl/down_cnt_reload_if.sv
// down_cnt_reload control/status bundle.
// master drives controls, slave is the counter.
interface down_cnt_reload_if #(
  parameter int W = 8
);
  logic         ce;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [W-1:0] q;
  logic         bo;
  logic         done;
  logic         busy;

  modport master (
    output ce, clr, load, load_val,
    output start, stop, periodic,
    input  q, bo, done, busy
  );

  modport slave (
    input  ce, clr, load, load_val,
    input  start, stop, periodic,
    output q, bo, done, busy
  );
endinterface

// File: rtl/down_cnt_reload.sv
// Programmable down-counter timer with
// runtime reload, periodic or one-shot.
module down_cnt_reload #(
  parameter int W              = 8,
  parameter int DEFAULT_RELOAD = 255
) (
  input logic              clk,
  input logic              rst,
  down_cnt_reload_if.slave bus
);
  import down_cnt_reload_pkg::*;

  st_t          state_q;
  st_t          state_d;
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] rel_q;
  logic [W-1:0] rel_eff;
  logic         done_q;
  logic         busy_q;

  logic         do_clr;
  logic         do_stop;
  logic         do_start;
  logic         do_tick;
  logic         do_exit;
  logic         at_zero;

  // A same-cycle load bypasses into start/reload.
  assign rel_eff = bus.load ? bus.load_val : rel_q;
  assign at_zero = (q_q == '0);

  // Mutually exclusive actions: clr > stop > start > ce.
  assign do_clr   = bus.clr;
  assign do_stop  = bus.stop & ~bus.clr;
  assign do_start = bus.start & ~bus.clr
                  & ~bus.stop;
  assign do_tick  = bus.ce & is_run(state_q)
                  & ~bus.clr & ~bus.stop
                  & ~bus.start;
  assign do_exit  = (state_q == ST_DONE)
                  & ~bus.clr & ~bus.stop
                  & ~bus.start;

  // Borrow-out only on an accepted tick at zero.
  assign bus.bo   = do_tick & at_zero;
  assign bus.q    = q_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

  // Next state and next count.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    unique case (1'b1)
      do_clr: begin
        state_d = ST_IDLE;
        q_d     = '0;
      end
      do_stop: begin
        state_d = ST_IDLE;
      end
      do_start: begin
        state_d = ST_RUN;
        q_d     = rel_eff;
      end
      do_tick: begin
        if (!at_zero) begin
          q_d = q_q - 1'b1;
        end else if (bus.periodic) begin
          q_d = rel_eff;
        end else begin
          state_d = ST_DONE;
        end
      end
      do_exit: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State, count and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d == ST_RUN);
    end
  end

  // Reload register; load is always taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_q <= W'(DEFAULT_RELOAD);
    end else if (bus.load) begin
      rel_q <= bus.load_val;
    end
  end

endmodule

// File: tb/tb_down_cnt_reload.sv
// Self-checking bench for down_cnt_reload.
// Directed scenarios then random traffic.
module tb_down_cnt_reload;

  logic clk = 1'b0;
  logic rst = 1'b0;

  down_cnt_reload_if #(.W(8)) bus ();

  down_cnt_reload #(
    .W(8),
    .DEFAULT_RELOAD(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integers and flags.
  int m_q;
  int m_rel;
  bit m_running;
  bit m_finish;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q       = 0;
    m_rel     = 255;
    m_running = 0;
    m_finish  = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".q"}, 32'(bus.q), m_q);
    chk({tag, ".busy"}, 32'(bus.busy),
        32'(m_running));
    chk({tag, ".done"}, 32'(bus.done),
        32'(m_finish));
  endtask

  // One clock with the given inputs.
  task automatic cyc(
    input bit ce, input bit clr,
    input bit ld, input int lv,
    input bit st, input bit sp,
    input bit per, input string tag
  );
    int  eff;
    bit  exp_bo;
    bus.ce       = ce;
    bus.clr      = clr;
    bus.load     = ld;
    bus.load_val = 8'(lv);
    bus.start    = st;
    bus.stop     = sp;
    bus.periodic = per;
    #1;
    eff    = ld ? lv : m_rel;
    exp_bo = ce && m_running && m_q == 0
             && !clr && !sp && !st;
    chk({tag, ".bo"}, 32'(bus.bo), 32'(exp_bo));
    @(posedge clk);
    if (ld) m_rel = lv;
    if (clr) begin
      m_q       = 0;
      m_running = 0;
      m_finish  = 0;
    end else if (sp) begin
      m_running = 0;
      m_finish  = 0;
    end else if (st) begin
      m_q       = eff;
      m_running = 1;
      m_finish  = 0;
    end else if (m_running && ce) begin
      if (m_q > 0) m_q = m_q - 1;
      else if (per) m_q = eff;
      else begin
        m_running = 0;
        m_finish  = 1;
      end
    end else begin
      m_finish = 0;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic idle_in();
    bus.ce       = 0;
    bus.clr      = 0;
    bus.load     = 0;
    bus.load_val = '0;
    bus.start    = 0;
    bus.stop     = 0;
    bus.periodic = 0;
  endtask

  initial begin
    idle_in();
    m_reset();

    // 1. reset values
    rst = 1'b1;
    #2;
    chk("rst.q", 32'(bus.q), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.bo", 32'(bus.bo), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 1, 0, 1, "t1.start");
    chk("t1.q255", 32'(bus.q), 255);
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 0, 0, 0, 1, "t1.run");
    chk("t1.q251", 32'(bus.q), 251);
    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("t1.arst.q", 32'(bus.q), 0);
    chk("t1.arst.busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 1, "t1.post");
    chk("t1.idle.q", 32'(bus.q), 0);

    // 2. load+start 3, periodic
    cyc(1, 0, 1, 3, 1, 0, 1, "t2.ls");
    chk("t2.q3", 32'(bus.q), 3);
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 0, 0, 0, 0, 1, "t2.run");
    chk("t2.q2", 32'(bus.q), 2);
    cyc(0, 0, 0, 0, 0, 1, 1, "t2.stop");

    // 3. reload 2, one-shot, ce every 3rd
    cyc(0, 0, 1, 2, 0, 0, 0, "t3.ld");
    cyc(0, 0, 0, 0, 1, 0, 0, "t3.st");
    for (int i = 0; i < 12; i++)
      cyc(i % 3 == 2, 0, 0, 0, 0, 0, 0, "t3.run");
    chk("t3.q0", 32'(bus.q), 0);
    chk("t3.busy", 32'(bus.busy), 0);

    // 4. reload 0, periodic, ce continuous
    cyc(0, 0, 1, 0, 1, 0, 1, "t4.ls");
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, 0, 0, 1, "t4.run");
    cyc(0, 0, 0, 0, 0, 1, 1, "t4.stop");

    // 5. load 5 while running at q=2
    cyc(0, 0, 1, 7, 1, 0, 1, "t5.ls");
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, 0, 0, 1, "t5.run");
    chk("t5.q2", 32'(bus.q), 2);
    cyc(1, 0, 1, 5, 0, 0, 1, "t5.ld");
    cyc(1, 0, 0, 0, 0, 0, 1, "t5.z");
    cyc(1, 0, 0, 0, 0, 0, 1, "t5.rl");
    chk("t5.q5", 32'(bus.q), 5);

    // 6. all controls together, then stop
    cyc(1, 1, 0, 0, 1, 1, 1, "t6.all");
    chk("t6.q0", 32'(bus.q), 0);
    cyc(0, 0, 0, 0, 1, 0, 1, "t6.st");
    cyc(1, 0, 0, 0, 0, 0, 1, "t6.dec");
    cyc(1, 0, 0, 0, 0, 1, 1, "t6.stop");
    chk("t6.q4", 32'(bus.q), 4);
    cyc(1, 0, 0, 0, 0, 0, 1, "t6.hold");
    chk("t6.hold4", 32'(bus.q), 4);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0,
          $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 6)),
          $urandom_range(0, 14) == 0,
          $urandom_range(0, 30) == 0,
          $urandom_range(0, 2) != 0,
          "rnd");
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
